// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller and its multiply/divide sequencer.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

  localparam logic MD_MULT = 1'b0;
  localparam logic MD_DIV  = 1'b1;

  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF  = 33;

endpackage

// File: rtl/md_seq.sv
// Multiply/divide sequencer: tracks an in-flight MD op and strobes the HI/LO write
// exactly LAT cycles after launch, counting the launch cycle as the first.
//
// state   | meaning
// MD_IDLE | no MD op in flight, a new op may launch
// MD_BUSY | op in flight, counter holds cycles left through the result cycle
// MD_DONE | result cycle, HI/LO written, back to idle next
module md_seq import pipe_ctrl_pkg::*; #(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
) (
  input  logic Clk,
  input  logic Reset,
  input  logic start,
  input  logic op,
  output logic idle,
  output logic busy,
  output logic result_wr
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  md_state_t       state;
  logic [CW-1:0]   cnt;

  // The counter keeps running while the pipeline is frozen; only Reset stops it.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= MD_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (start) begin
            state <= MD_BUSY;
            cnt   <= (op == MD_DIV) ? CW'(DIV_LAT - 1) : CW'(MULT_LAT - 1);
          end
        end
        MD_BUSY: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(2)) state <= MD_DONE;
        end
        MD_DONE: begin
          cnt   <= cnt - CW'(1);
          state <= MD_IDLE;
        end
        default: begin
          state <= MD_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign idle      = (state == MD_IDLE);
  assign busy      = (state != MD_IDLE);
  assign result_wr = (state == MD_DONE) && !Reset;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: freeze/branch/stall priority decode, MD unit launch
// and a saturating stall-cycle counter.
module pipe_hazard_ctrl import pipe_ctrl_pkg::*; #(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF,
  parameter int CNT_W    = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [4:0]       ID_ra,
  input  logic [4:0]       ID_rb,
  input  logic             ID_UsesRa,
  input  logic             ID_UsesRb,
  input  logic [4:0]       Ex_rw,
  input  logic             Ex_RegWr,
  input  logic [1:0]       Ex_MemRead,
  input  logic             Ex_BranchTaken,
  input  logic             Mem_Ready,
  input  logic             ID_MDStart,
  input  logic             ID_MDOp,
  input  logic             ID_MDRead,
  output logic             PC_Wr,
  output logic             IF_ID_Wr,
  output logic             IF_ID_Flush,
  output logic             hazard,
  output logic             BranchBubble,
  output logic             Freeze,
  output logic             MD_Start,
  output logic             MD_Busy,
  output logic             MD_ResultWr,
  output logic [CNT_W-1:0] StallCnt
);

  logic md_idle;
  logic load_use;
  logic md_stall;

  assign load_use = (Ex_MemRead != 2'b00) && Ex_RegWr && (Ex_rw != 5'd0) &&
                    ((ID_UsesRa && (ID_ra == Ex_rw)) || (ID_UsesRb && (ID_rb == Ex_rw)));

  // Reset forces the decode to see an idle MD unit regardless of the old state.
  assign md_stall = !md_idle && !Reset && (ID_MDStart || ID_MDRead);

  always_comb begin
    PC_Wr        = 1'b0;
    IF_ID_Wr     = 1'b0;
    IF_ID_Flush  = 1'b0;
    hazard       = 1'b0;
    BranchBubble = 1'b0;
    Freeze       = 1'b0;
    if (!Mem_Ready) begin
      Freeze = 1'b1;
    end else if (Ex_BranchTaken) begin
      PC_Wr        = 1'b1;
      IF_ID_Wr     = 1'b1;
      IF_ID_Flush  = 1'b1;
      BranchBubble = 1'b1;
    end else if (md_stall || load_use) begin
      hazard = 1'b1;
    end else begin
      PC_Wr    = 1'b1;
      IF_ID_Wr = 1'b1;
    end
  end

  // Launch only on a clean "normal" cycle; md_stall is false whenever md_idle is set.
  assign MD_Start = ID_MDStart && md_idle && !Reset && Mem_Ready &&
                    !Ex_BranchTaken && !load_use;

  md_seq #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT)
  ) u_md_seq (
    .Clk       (Clk),
    .Reset     (Reset),
    .start     (MD_Start),
    .op        (ID_MDOp),
    .idle      (md_idle),
    .busy      (MD_Busy),
    .result_wr (MD_ResultWr)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      StallCnt <= '0;
    end else if (hazard && (StallCnt != '1)) begin
      StallCnt <= StallCnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; a narrow stall counter exposes saturation.
module tb_pipe_hazard_ctrl;

  localparam int CW = 4;

  logic          Clk = 1'b0;
  logic          Reset;
  logic [4:0]    ID_ra, ID_rb, Ex_rw;
  logic          ID_UsesRa, ID_UsesRb, Ex_RegWr;
  logic [1:0]    Ex_MemRead;
  logic          Ex_BranchTaken, Mem_Ready;
  logic          ID_MDStart, ID_MDOp, ID_MDRead;
  logic          PC_Wr, IF_ID_Wr, IF_ID_Flush, hazard, BranchBubble, Freeze;
  logic          MD_Start, MD_Busy, MD_ResultWr;
  logic [CW-1:0] StallCnt;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_stall = 0;
  int res_pulses;

  always #5 Clk = ~Clk;

  pipe_hazard_ctrl #(.MULT_LAT(5), .DIV_LAT(33), .CNT_W(CW)) dut (
    .Clk(Clk), .Reset(Reset),
    .ID_ra(ID_ra), .ID_rb(ID_rb), .ID_UsesRa(ID_UsesRa), .ID_UsesRb(ID_UsesRb),
    .Ex_rw(Ex_rw), .Ex_RegWr(Ex_RegWr), .Ex_MemRead(Ex_MemRead),
    .Ex_BranchTaken(Ex_BranchTaken), .Mem_Ready(Mem_Ready),
    .ID_MDStart(ID_MDStart), .ID_MDOp(ID_MDOp), .ID_MDRead(ID_MDRead),
    .PC_Wr(PC_Wr), .IF_ID_Wr(IF_ID_Wr), .IF_ID_Flush(IF_ID_Flush),
    .hazard(hazard), .BranchBubble(BranchBubble), .Freeze(Freeze),
    .MD_Start(MD_Start), .MD_Busy(MD_Busy), .MD_ResultWr(MD_ResultWr),
    .StallCnt(StallCnt)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    ID_ra = 5'd0; ID_rb = 5'd0; ID_UsesRa = 1'b0; ID_UsesRb = 1'b0;
    Ex_rw = 5'd0; Ex_RegWr = 1'b0; Ex_MemRead = 2'd0;
    Ex_BranchTaken = 1'b0; Mem_Ready = 1'b1;
    ID_MDStart = 1'b0; ID_MDOp = 1'b0; ID_MDRead = 1'b0;
  endtask

  task automatic settle();
    #3;
  endtask

  // Advances one clock and keeps the stall-count model in step.
  task automatic tick(input logic exp_haz);
    if (Reset) exp_stall = 0;
    else if (exp_haz && exp_stall < (1 << CW) - 1) exp_stall++;
    @(posedge Clk);
    #1;
  endtask

  task automatic set_load_use(input logic [4:0] r);
    Ex_MemRead = 2'd1; Ex_RegWr = 1'b1; Ex_rw = r; ID_ra = r; ID_UsesRa = 1'b1;
  endtask

  initial begin
    idle_inputs();
    Reset = 1'b1;
    @(posedge Clk); #1;
    tick(1'b0);
    Reset = 1'b0;
    settle();
    chk("rst_stallcnt", StallCnt, 0);
    chk("rst_md_busy", MD_Busy, 0);
    chk("rst_pc_wr", PC_Wr, 1);
    chk("rst_ifid_wr", IF_ID_Wr, 1);
    chk("rst_hazard", hazard, 0);
    chk("rst_freeze", Freeze, 0);
    tick(1'b0);

    // Load-use on ra
    set_load_use(5'd8);
    settle();
    chk("lu_hazard", hazard, 1);
    chk("lu_pc_wr", PC_Wr, 0);
    chk("lu_ifid_wr", IF_ID_Wr, 0);
    tick(1'b1);
    idle_inputs();
    settle();
    chk("lu_hazard_clear", hazard, 0);
    chk("lu_stallcnt", StallCnt, 1);
    tick(1'b0);

    // Load to $0 never stalls
    set_load_use(5'd0);
    settle();
    chk("lu0_hazard", hazard, 0);
    chk("lu0_pc_wr", PC_Wr, 1);
    tick(1'b0);

    // rb match without ID_UsesRb is not a hazard, with it is
    idle_inputs();
    Ex_MemRead = 2'd2; Ex_RegWr = 1'b1; Ex_rw = 5'd9; ID_rb = 5'd9;
    settle();
    chk("rb_unused_hazard", hazard, 0);
    ID_UsesRb = 1'b1;
    settle();
    chk("rb_used_hazard", hazard, 1);
    tick(1'b1);
    idle_inputs();
    settle();
    chk("rb_stallcnt", StallCnt, exp_stall);

    // Branch beats load-use and blocks an MD launch
    set_load_use(5'd8);
    Ex_BranchTaken = 1'b1; ID_MDStart = 1'b1; ID_MDOp = 1'b1;
    settle();
    chk("br_bubble", BranchBubble, 1);
    chk("br_flush", IF_ID_Flush, 1);
    chk("br_hazard", hazard, 0);
    chk("br_pc_wr", PC_Wr, 1);
    chk("br_md_start", MD_Start, 0);
    tick(1'b0);
    idle_inputs();
    settle();
    chk("br_md_busy", MD_Busy, 0);

    // Freeze beats branch and load-use
    set_load_use(5'd8);
    Ex_BranchTaken = 1'b1; Mem_Ready = 1'b0;
    settle();
    chk("frz_freeze", Freeze, 1);
    chk("frz_pc_wr", PC_Wr, 0);
    chk("frz_ifid_wr", IF_ID_Wr, 0);
    chk("frz_hazard", hazard, 0);
    chk("frz_bubble", BranchBubble, 0);
    chk("frz_flush", IF_ID_Flush, 0);
    tick(1'b0);
    idle_inputs();

    // Multiply with a 3-cycle freeze right after launch
    ID_MDStart = 1'b1; ID_MDOp = 1'b0;
    settle();
    chk("mul_md_start", MD_Start, 1);
    tick(1'b0);
    ID_MDStart = 1'b0;
    for (int c = 2; c <= 7; c++) begin
      Mem_Ready = (c >= 2 && c <= 4) ? 1'b0 : 1'b1;
      settle();
      if (c <= 4) chk($sformatf("mul_freeze_c%0d", c), Freeze, 1);
      chk($sformatf("mul_resultwr_c%0d", c), MD_ResultWr, (c == 5) ? 1 : 0);
      chk($sformatf("mul_busy_c%0d", c), MD_Busy, (c <= 5) ? 1 : 0);
      tick(1'b0);
    end
    idle_inputs();

    // Divide then mfhi: stalls through the result cycle, saturating StallCnt
    ID_MDStart = 1'b1; ID_MDOp = 1'b1;
    settle();
    chk("div_md_start", MD_Start, 1);
    tick(1'b0);
    ID_MDStart = 1'b0; ID_MDRead = 1'b1;
    for (int c = 2; c <= 35; c++) begin
      settle();
      chk($sformatf("div_hazard_c%0d", c), hazard, (c <= 33) ? 1 : 0);
      chk($sformatf("div_resultwr_c%0d", c), MD_ResultWr, (c == 33) ? 1 : 0);
      tick(c <= 33);
    end
    ID_MDRead = 1'b0;
    settle();
    chk("div_stallcnt_sat", StallCnt, exp_stall);
    chk("div_stallcnt_max", exp_stall, 15);

    // Reset in cycle 10 of a divide aborts it silently
    ID_MDStart = 1'b1; ID_MDOp = 1'b1;
    settle();
    chk("rdiv_md_start", MD_Start, 1);
    tick(1'b0);
    ID_MDStart = 1'b0;
    for (int c = 2; c <= 9; c++) tick(1'b0);
    Reset = 1'b1; ID_MDRead = 1'b1;
    settle();
    chk("rdiv_hazard_in_reset", hazard, 0);
    chk("rdiv_pc_wr_in_reset", PC_Wr, 1);
    tick(1'b0);
    Reset = 1'b0; ID_MDRead = 1'b0;
    settle();
    chk("rdiv_md_busy", MD_Busy, 0);
    chk("rdiv_stallcnt", StallCnt, exp_stall);
    res_pulses = 0;
    for (int c = 0; c < 30; c++) begin
      settle();
      if (MD_ResultWr) res_pulses++;
      tick(1'b0);
    end
    chk("rdiv_no_resultwr", res_pulses, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
